// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLL DRP master: bus widths, FSM states and a
// saturating counter helper.
`timescale 1ns/1ps
package pll_drp_pkg;

    localparam int DRP_ADDR_W = 6;
    localparam int DRP_DATA_W = 8;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        PLL_RST,
        LOCK_WAIT
    } drp_state_t;

    // Counters stop at their limit instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + 16'd1;
    endfunction

endpackage

// File: rtl/pll_drp_master_sync_2ff.sv
// Generic two-flop synchroniser with a synchronous reset to zero. It brings
// signals from other clock domains, such as the PLL lock flag, into clk.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; the second gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_drp_master.sv
// DRP initiator for the EF2 PLL. It turns single register read/write requests
// into DRP strobe sequences. After the last write of a batch it pulses the PLL
// reset and waits until the lock flag has stayed clean for long enough.
`timescale 1ns/1ps
module pll_drp_master
    import pll_drp_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_last,
    input  logic [DRP_ADDR_W-1:0] req_addr,
    input  logic [DRP_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DRP_DATA_W-1:0] rsp_rdata,
    output logic                  drp_dclk,
    output logic                  drp_dcs,
    output logic                  drp_dwe,
    output logic [DRP_ADDR_W-1:0] drp_daddr,
    output logic [DRP_DATA_W-1:0] drp_di,
    input  logic [DRP_DATA_W-1:0] drp_do,
    output logic                  pll_reset,
    input  logic                  pll_extlock,
    output logic                  busy,
    output logic                  locked,
    output logic                  lock_err
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LIM   = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    drp_state_t       state;
    logic             lat_we;
    logic             lat_last;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic             lock_s;
    logic [CNT_W-1:0] stable_next;
    logic             stable_hit;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_extlock),
        .q     (lock_s)
    );

    // Next value of the lock qualifier: one low sample restarts the count.
    always_comb begin
        stable_next = '0;
        if (lock_s) begin
            stable_next = sat_inc(stable_cnt, STABLE_LIM);
        end
        stable_hit = (stable_next == STABLE_LIM);
    end

    // Main sequencer: request handshake, DRP strobes, PLL reset and lock wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_last    <= 1'b0;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            drp_dclk    <= 1'b0;
            drp_dcs     <= 1'b0;
            drp_dwe     <= 1'b0;
            drp_daddr   <= '0;
            drp_di      <= '0;
            pll_reset   <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            lock_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state != PLL_RST) begin
                stable_cnt <= stable_next;
                locked     <= stable_hit;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_last  <= req_last;
                        lock_err  <= 1'b0;
                        drp_daddr <= req_addr;
                        drp_di    <= req_wdata;
                        drp_dwe   <= req_we;
                        drp_dcs   <= 1'b1;
                        drp_dclk  <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    drp_dclk <= 1'b1;
                    state    <= STROBE;
                end
                STROBE: begin
                    drp_dclk <= 1'b0;
                    drp_dcs  <= 1'b0;
                    drp_dwe  <= 1'b0;
                    if (!lat_we) begin
                        rsp_rdata <= drp_do;
                        rsp_valid <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (lat_we && lat_last) begin
                        pll_reset  <= 1'b1;
                        locked     <= 1'b0;
                        stable_cnt <= '0;
                        rst_cnt    <= '0;
                        state      <= PLL_RST;
                    end else begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                PLL_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        pll_reset   <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= LOCK_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                LOCK_WAIT: begin
                    if (stable_hit) begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (timeout_cnt >= TIMEOUT_LAST) begin
                        lock_err  <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timeout_cnt <= sat_inc(timeout_cnt, TIMEOUT_LAST);
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    pll_reset <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_master.sv
// Self-checking bench for pll_drp_master. It contains a behavioural PLL with a
// DRP register file and a lock model. DRP strobes and read responses go
// through scoreboard queues. Timing and lock behaviour are checked with
// directed per-cycle vectors.
`timescale 1ns/1ps
module tb_pll_drp_master;
    import pll_drp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic       req_last = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       drp_dclk;
    logic       drp_dcs;
    logic       drp_dwe;
    logic [5:0] drp_daddr;
    logic [7:0] drp_di;
    logic [7:0] drp_do;
    logic       pll_reset;
    logic       pll_extlock;
    logic       busy;
    logic       locked;
    logic       lock_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pll_mem [64];
    logic [7:0]  drp_do_q = '0;
    logic        model_lock = 1'b0;
    int          relock_delay = 0;
    int          since_rst = 0;
    logic        ovr_en = 1'b0;
    logic        ovr_val = 1'b0;
    logic        rst_width_check = 1'b1;
    int          rst_run = 0;

    logic [7:0]  rsp_q [$];
    logic [15:0] drp_q [$];

    // Per-cycle vectors {pll_reset,busy,dcs,dclk,dwe,rsp_valid} from SETUP to IDLE.
    logic [5:0] exp_wr [4] = '{6'b011010, 6'b011110, 6'b010000, 6'b000000};
    logic [5:0] exp_rd [4] = '{6'b011000, 6'b011100, 6'b010001, 6'b000000};

    assign drp_do      = drp_do_q;
    assign pll_extlock = ovr_en ? ovr_val : model_lock;

    pll_drp_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_last    (req_last),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .drp_dclk    (drp_dclk),
        .drp_dcs     (drp_dcs),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .pll_reset   (pll_reset),
        .pll_extlock (pll_extlock),
        .busy        (busy),
        .locked      (locked),
        .lock_err    (lock_err)
    );

    // 100 MHz reference clock.
    always #5 clk = ~clk;

    // PLL register file: the DRP access happens on the rising edge of dclk.
    always @(posedge drp_dclk) begin
        if (drp_dcs) begin
            if (drp_dwe) pll_mem[drp_daddr] <= drp_di;
            else         drp_do_q <= pll_mem[drp_daddr];
        end
    end

    // PLL lock model: it loses lock in reset and relocks relock_delay cycles after release (-1 = never).
    always @(negedge clk) begin
        if (pll_reset) begin
            since_rst  = 0;
            model_lock = 1'b0;
        end else begin
            if (since_rst < 1000000) since_rst++;
            if (relock_delay >= 0 && since_rst >= relock_delay) model_lock = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Scoreboard monitor: pops expectations when the DUT strobes DRP or returns read data.
    always @(negedge clk) begin
        if (drp_dclk) begin
            if (drp_q.size() == 0)
                failNow("drp_unexpected", $sformatf("strobe addr 0x%0h with none pending", drp_daddr));
            else
                checkOutput("drp_strobe", {drp_dcs, drp_dwe, drp_daddr, drp_di}, drp_q.pop_front());
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0)
                failNow("rsp_unexpected", $sformatf("rdata 0x%0h with no read pending", rsp_rdata));
            else
                checkOutput("rsp_rdata", rsp_rdata, rsp_q.pop_front());
        end
        if (pll_reset) begin
            rst_run++;
        end else if (rst_run != 0) begin
            if (rst_width_check) checkOutput("pll_reset_width", rst_run, 16);
            rst_run = 0;
        end
    end

    // Issue one request, queue its expected strobe/response, and return just after the accept edge.
    task automatic applyStimulus(input logic we, input logic last, input logic [5:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_rdata);
        int n;
        drp_q.push_back({1'b1, we, addr, wdata});
        if (!we) rsp_q.push_back(exp_rdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_last  = last;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            failNow("req_ready_timeout", "request never accepted");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int bound, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < bound) begin
            cycles++;
            @(negedge clk);
        end
        if (busy) failNow("idle_timeout", $sformatf("busy after %0d cycles", bound));
    endtask

    task automatic waitLevel(input string name, input logic level, input int bound);
        int n;
        n = 0;
        while (pll_reset !== level && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (pll_reset !== level) failNow(name, "pll_reset level not reached");
    endtask

    // Directed test sequence.
    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) pll_mem[i] = 8'h00;
        pll_mem[6'h12] = 8'h5C;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {req_ready, rsp_valid, rsp_rdata, drp_dclk, drp_dcs, drp_dwe,
                    drp_daddr, drp_di, pll_reset, busy, locked, lock_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("ready_after_reset", req_ready, 1);
        repeat (80) @(negedge clk);
        checkOutput("prebatch_locked", locked, 1);

        $display("[TB] single write");
        applyStimulus(1'b1, 1'b0, 6'h05, 8'hA3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("wr_cycle%0d", i),
                        {pll_reset, busy, drp_dcs, drp_dclk, drp_dwe, rsp_valid}, exp_wr[i]);
        end

        $display("[TB] single read");
        applyStimulus(1'b0, 1'b0, 6'h12, 8'h00, 8'h5C);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rd_cycle%0d", i),
                        {pll_reset, busy, drp_dcs, drp_dclk, drp_dwe, rsp_valid}, exp_rd[i]);
        end
        repeat (3) @(negedge clk);
        checkOutput("rsp_rdata_hold", rsp_rdata, 8'h5C);
        applyStimulus(1'b0, 1'b1, 6'h05, 8'h00, 8'hA3);
        waitIdle(20, cyc);
        checkOutput("read_last_no_reset", rst_run, 0);

        $display("[TB] batch with relock");
        relock_delay = 100;
        applyStimulus(1'b1, 1'b0, 6'h08, 8'h11, 8'h00);
        waitIdle(20, cyc);
        applyStimulus(1'b1, 1'b0, 6'h09, 8'h22, 8'h00);
        waitIdle(20, cyc);
        applyStimulus(1'b1, 1'b1, 6'h0A, 8'h33, 8'h00);
        waitLevel("pll_reset_rise", 1'b1, 10);
        checkOutput("locked_in_pll_rst", locked, 0);
        waitLevel("pll_reset_fall", 1'b0, 40);
        cyc = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("lock_wait_in_range", (cyc >= 160 && cyc <= 172), 1);
        checkOutput("batch_locked", locked, 1);
        checkOutput("batch_lock_err", lock_err, 0);
        applyStimulus(1'b0, 1'b0, 6'h09, 8'h00, 8'h22);
        waitIdle(20, cyc);

        $display("[TB] lock timeout");
        relock_delay = -1;
        applyStimulus(1'b1, 1'b1, 6'h0B, 8'h44, 8'h00);
        waitLevel("to_reset_rise", 1'b1, 10);
        waitLevel("to_reset_fall", 1'b0, 40);
        cyc = 0;
        while (busy && cyc < 70000) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("timeout_cycles", cyc, 65535);
        checkOutput("timeout_lock_err", lock_err, 1);
        checkOutput("timeout_locked", locked, 0);
        @(negedge clk);
        checkOutput("timeout_ready", req_ready, 1);
        relock_delay = 0;
        applyStimulus(1'b0, 1'b0, 6'h0B, 8'h00, 8'h44);
        @(negedge clk);
        checkOutput("lock_err_cleared", lock_err, 0);
        waitIdle(20, cyc);

        $display("[TB] extlock glitch");
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("lock_drop", locked, 0);
        ovr_val = 1'b1;
        repeat (42) @(negedge clk);
        checkOutput("lock_pre_glitch", locked, 0);
        ovr_val = 1'b0;
        @(negedge clk);
        ovr_val = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!locked && cyc < 200);
        checkOutput("relock_after_glitch", cyc, 66);
        ovr_en = 1'b0;

        $display("[TB] reset during transfer");
        rst_width_check = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'h20, 8'h77, 8'h00);
        cyc = 0;
        while (!drp_dclk && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_strobe_zero", {req_ready, rsp_valid, rsp_rdata, drp_dclk, drp_dcs, drp_dwe,
                    drp_daddr, drp_di, pll_reset, busy, locked, lock_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_strobe_ready", req_ready, 1);
        applyStimulus(1'b1, 1'b1, 6'h21, 8'h55, 8'h00);
        waitLevel("abort_rst_rise", 1'b1, 10);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_pllrst_zero", {req_ready, rsp_valid, rsp_rdata, drp_dclk, drp_dcs, drp_dwe,
                    drp_daddr, drp_di, pll_reset, busy, locked, lock_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_pllrst_ready", req_ready, 1);
        applyStimulus(1'b0, 1'b0, 6'h21, 8'h00, 8'h55);
        waitIdle(20, cyc);
        repeat (3) @(negedge clk);

        checkOutput("rsp_queue_empty", rsp_q.size(), 0);
        checkOutput("drp_queue_empty", drp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
